fp_alu_driver: RTL and testbench
================================

FP_ALU_DRIVER -- requirements
Module: fp_alu_driver

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 8, maximum cycles in WAIT_DONE before an error response.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  driver can accept a request.
REQ-006 req_a  in  32  operand A, IEEE-754 single.
REQ-007 req_b  in  32  operand B, IEEE-754 single.
REQ-008 req_op  in  2  opcode: 00 add, 01 subtract.
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_result  out  32  assembled result.
REQ-012 rsp_err  out  1  response is an error, meaning the ALU timed out.
REQ-013 alu_start  out  1  start pulse to the ALU.
REQ-014 alu_opcode  out  2  opcode to the ALU.
REQ-015 alu_in  out  8  operand byte bus to the ALU.
REQ-016 alu_out  in  8  result byte bus from the ALU.
REQ-017 alu_done  in  1  ALU result-phase flag.

Function
REQ-018 FSM states SHALL be IDLE, START, SEND, WAIT_DONE, RECV, RESP.
REQ-019 IDLE SHALL:
- assert req_ready;
- on req_valid&&req_ready, register req_a, req_b and req_op;
- go to START.
REQ-020 START SHALL last exactly 1 cycle (C0), with alu_start=1 and alu_in=0x00; alu_start SHALL be 0 in every other state.
REQ-021 SEND SHALL last 8 cycles, C1..C8, with a 3-bit counter.
- alu_in order: A[7:0], A[15:8], A[23:16], A[31:24], B[7:0], B[15:8], B[23:16], B[31:24].
- alu_in SHALL be 0x00 outside SEND.
REQ-022 alu_opcode SHALL be registered from req_op at acceptance and held constant until the next acceptance.
REQ-023 WAIT_DONE SHALL be entered at C9.
- The first cycle in which alu_done=1 SHALL capture alu_out into result[7:0] and go to RECV.
- Nominal: captured at C11.
REQ-024 RECV SHALL capture alu_out on 3 consecutive cycles into result[15:8], result[23:16] and result[31:24], then go to RESP.
- Captured regardless of alu_done.
REQ-025 If alu_done stays 0 for TIMEOUT_CYCLES consecutive cycles in WAIT_DONE:
- go to RESP with rsp_err=1 and rsp_result=0;
- return to IDLE after the handshake.
REQ-026 RESP SHALL hold rsp_valid=1 and rsp_result/rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-027 Latency: rsp_valid SHALL first be high 15 cycles after the acceptance cycle (C15) when the ALU behaves nominally.
REQ-028 req_ready SHALL be 0 in every state except IDLE; one transaction in flight at most.
REQ-029 rsp_valid and rsp_ready both high SHALL complete the handshake, and req_ready SHALL be 1 in the next cycle.

Reset
REQ-030 On rst_n=0, in any state including mid-transaction, all outputs SHALL be driven at once as follows:
- FSM=IDLE;
- req_ready=1 once in IDLE;
- rsp_valid=0, rsp_err=0, rsp_result=0;
- alu_start=0, alu_in=0x00, alu_opcode=00;
- counters=0.
REQ-031 After reset release, the first accepted request SHALL behave per REQ-019..REQ-027 with no residual data.

Structure
REQ-032 Shared package fp_alu_pkg SHALL hold:
- opcode constants OP_ADD=2'b00, OP_SUB=2'b01;
- the driver state enum;
- constants for operand bytes (8) and result bytes (4).
REQ-033 The block SHALL be a single module with no sub-modules; the serializer, deserializer and watchdog live inline with the FSM.

Verification
REQ-034 Bench SHALL connect the driver to the team's byte-serial FP ALU and cover:
- Add: A=0x3F800000, B=0x40000000, op=00 -> alu_in C1..C8 = 00 00 80 3F 00 00 00 40; rsp_result=0x40400000, rsp_err=0, rsp_valid at C15.
- Subtract: A=0x40400000, B=0x3F800000, op=01 -> rsp_result=0x40000000; alu_opcode=01 from C0 through C14.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result stable, req_ready=0 throughout, req_valid ignored; release -> req_ready=1 next cycle.
- Timeout: alu_done tied 0 -> rsp_valid with rsp_err=1, rsp_result=0 after 8 WAIT_DONE cycles; next request completes normally.
- Reset mid-SEND (at C4) -> alu_start=0, alu_in=0x00, rsp_valid=0; req_ready=1; fresh add (0x3F800000+0x3F800000) -> 0x40000000.
- Back-to-back: two requests with rsp_ready=1 and req_valid always high -> second acceptance in the cycle after the first response handshake; both results correct.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the byte-serial FP ALU driver: opcodes, FSM states,
// transfer sizes and the operand byte selector used by the serializer.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // Two 32-bit operands go out as 8 bytes; one 32-bit result comes back as 4.
  localparam int OPERAND_BYTES = 8;
  localparam int RESULT_BYTES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RECV      = 3'd4,
    ST_RESP      = 3'd5
  } drv_state_t;

  // Byte idx of the packed operand pair {B, A}; byte 0 is A[7:0].
  function automatic logic [7:0] operand_byte(input logic [63:0] ops,
                                              input logic [2:0]  idx);
    logic [63:0] shifted;
    shifted = ops >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/fp_alu_driver.sv
// Request/response front end for the byte-serial FP ALU. One request at a
// time: latch operands, pulse start, serialize 8 operand bytes, wait for the
// ALU result phase (with a watchdog), deserialize 4 result bytes, then hold
// the response until the consumer takes it.
module fp_alu_driver
  import fp_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [1:0]  i_req_op,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_err,
  output logic        o_alu_start,
  output logic [1:0]  o_alu_opcode,
  output logic [7:0]  o_alu_in,
  input  logic [7:0]  i_alu_out,
  input  logic        i_alu_done
);

  // Watchdog counts 0..TIMEOUT_CYCLES-1 while waiting for alu_done.
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  drv_state_t        r_state;
  logic              r_req_ready;
  logic [63:0]       r_operands;
  logic [1:0]        r_opcode;
  logic              r_alu_start;
  logic [7:0]        r_alu_in;
  logic [2:0]        r_send_cnt;
  logic [1:0]        r_recv_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [31:0]       r_result;
  logic              r_rsp_err;
  logic              r_rsp_valid;

  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_result;
  assign o_rsp_err    = r_rsp_err;
  assign o_alu_start  = r_alu_start;
  assign o_alu_opcode = r_opcode;
  assign o_alu_in     = r_alu_in;

  // Driver FSM: every output is registered and set on the edge that enters
  // the cycle in which it must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_operands  <= '0;
      r_opcode    <= OP_ADD;
      r_alu_start <= 1'b0;
      r_alu_in    <= 8'h00;
      r_send_cnt  <= '0;
      r_recv_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_result    <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_operands  <= {i_req_b, i_req_a};
            r_opcode    <= i_req_op;
            r_result    <= '0;
            r_req_ready <= 1'b0;
            r_alu_start <= 1'b1;
            r_alu_in    <= 8'h00;
            r_state     <= ST_START;
          end
        end

        ST_START: begin
          // Start pulse lasts one cycle; first operand byte follows directly.
          r_alu_start <= 1'b0;
          r_send_cnt  <= '0;
          r_alu_in    <= operand_byte(r_operands, 3'd0);
          r_state     <= ST_SEND;
        end

        ST_SEND: begin
          if (r_send_cnt == 3'(OPERAND_BYTES - 1)) begin
            r_alu_in   <= 8'h00;
            r_wait_cnt <= '0;
            r_state    <= ST_WAIT_DONE;
          end else begin
            r_send_cnt <= r_send_cnt + 3'd1;
            r_alu_in   <= operand_byte(r_operands, r_send_cnt + 3'd1);
          end
        end

        ST_WAIT_DONE: begin
          if (i_alu_done) begin
            r_result[7:0] <= i_alu_out;
            r_recv_cnt    <= '0;
            r_state       <= ST_RECV;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            // ALU never entered its result phase: report an empty error.
            r_result    <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_RECV: begin
          // Remaining result bytes arrive on consecutive cycles; alu_done is
          // not re-checked here.
          case (r_recv_cnt)
            2'd0:    r_result[15:8]  <= i_alu_out;
            2'd1:    r_result[23:16] <= i_alu_out;
            default: r_result[31:24] <= i_alu_out;
          endcase
          if (r_recv_cnt == 2'(RESULT_BYTES - 2)) begin
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_recv_cnt <= r_recv_cnt + 2'd1;
          end
        end

        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_result    <= '0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_alu_start <= 1'b0;
          r_alu_in    <= 8'h00;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_alu_driver.sv
// Bench for fp_alu_driver: a byte-serial FP ALU responder with adjustable
// result latency (or none at all), a transaction-level expectation model
// checked every cycle, and directed plus random request sequences.
module tb_fp_alu_driver;
  import fp_alu_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_a = '0;
  logic [31:0] i_req_b = '0;
  logic [1:0]  i_req_op = 2'b00;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_result;
  logic        o_rsp_err;
  logic        o_alu_start;
  logic [1:0]  o_alu_opcode;
  logic [7:0]  o_alu_in;
  logic [7:0]  i_alu_out = '0;
  logic        i_alu_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // ALU behaviour knobs, changed only between transactions.
  int   alu_dly  = 2;
  logic alu_tie0 = 1'b0;

  fp_alu_driver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_err(o_rsp_err),
    .o_alu_start(o_alu_start), .o_alu_opcode(o_alu_opcode),
    .o_alu_in(o_alu_in), .i_alu_out(i_alu_out), .i_alu_done(i_alu_done)
  );

  always #5 clk = ~clk;

  // ---------------- IEEE-754 single arithmetic via double ----------------
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return {f[31], 63'd0};
    e = {3'b000, f[30:23]} + 11'd896;
    return {f[31], e, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    logic [30:0] keep;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e    = d[62:52] - 11'd896;
    keep = {e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || keep[0])) keep = keep + 31'd1;
    return {d[63], keep};
  endfunction

  // Exact double sum of two singles, rounded once to single (round-to-even).
  function automatic logic [31:0] fp_calc(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0]  op);
    logic [31:0] bb;
    real         x;
    bb = (op == OP_SUB) ? {~b[31], b[30:0]} : b;
    x  = $bitstoreal(f2d(a)) + $bitstoreal(f2d(bb));
    return d2f($realtobits(x));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom % 2), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- byte-serial FP ALU responder ----------------
  // Collects 8 operand bytes after the start pulse, then presents the 4
  // result bytes with alu_done=1 starting alu_dly cycles after the driver
  // enters its wait (first wait cycle = 9th cycle after start).
  logic        a_run = 1'b0;
  int          a_cnt = 0;
  logic [63:0] a_buf = '0;
  logic [31:0] a_res = '0;
  logic [1:0]  a_op  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_run <= 1'b0; a_cnt <= 0; a_buf <= '0; a_res <= '0; a_op <= '0;
      i_alu_done <= 1'b0; i_alu_out <= 8'h00;
    end else if (o_alu_start) begin
      a_run <= 1'b1; a_cnt <= 1; a_op <= o_alu_opcode;
      i_alu_done <= 1'b0; i_alu_out <= 8'($urandom);
    end else if (a_run) begin
      if (a_cnt >= 1 && a_cnt <= 8) a_buf[8*(a_cnt-1) +: 8] <= o_alu_in;
      if (a_cnt == 8) a_res <= fp_calc(a_buf[31:0], {o_alu_in, a_buf[55:32]}, a_op);
      a_cnt <= a_cnt + 1;
      if (!alu_tie0 && (a_cnt + 1 >= 9 + alu_dly) && (a_cnt + 1 <= 12 + alu_dly)) begin
        i_alu_done <= 1'b1;
        i_alu_out  <= a_res[8*(a_cnt+1-9-alu_dly) +: 8];
      end else begin
        i_alu_done <= 1'b0;
        i_alu_out  <= 8'($urandom);
      end
      if (a_cnt > 40) a_run <= 1'b0;
    end else begin
      i_alu_done <= 1'b0;
    end
  end

  // ---------------- transaction-level expectation model ----------------
  // m_k = cycles since the accepting edge (0 = start-pulse cycle).
  logic        m_busy    = 1'b0;
  int          m_k       = 0;
  int          m_resp_at = 0;
  logic [63:0] m_ops     = '0;
  logic [1:0]  m_op_reg  = '0;
  logic [31:0] m_exp     = '0;
  logic        m_err     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_k <= 0; m_resp_at <= 0; m_ops <= '0;
      m_op_reg <= 2'b00; m_exp <= '0; m_err <= 1'b0;
    end else if (!m_busy) begin
      if (i_req_valid) begin
        m_busy   <= 1'b1;
        m_k      <= 0;
        m_ops    <= {i_req_b, i_req_a};
        m_op_reg <= i_req_op;
        if (alu_tie0) begin
          m_exp <= '0; m_err <= 1'b1; m_resp_at <= 9 + TMO;
        end else begin
          m_exp <= fp_calc(i_req_a, i_req_b, i_req_op); m_err <= 1'b0;
          m_resp_at <= 13 + alu_dly;
        end
      end
    end else if (m_k >= m_resp_at && i_rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic       e_rv;
    logic [7:0] e_in;
    if (!rst_n) begin
      check("rst_req_ready",  64'(o_req_ready), 64'd1);
      check("rst_rsp_valid",  64'(o_rsp_valid), 64'd0);
      check("rst_rsp_err",    64'(o_rsp_err), 64'd0);
      check("rst_rsp_result", 64'(o_rsp_result), 64'd0);
      check("rst_alu_start",  64'(o_alu_start), 64'd0);
      check("rst_alu_in",     64'(o_alu_in), 64'd0);
      check("rst_alu_opcode", 64'(o_alu_opcode), 64'd0);
    end else begin
      e_rv = m_busy && (m_k >= m_resp_at);
      e_in = (m_busy && m_k >= 1 && m_k <= 8) ? m_ops[8*(m_k-1) +: 8] : 8'h00;
      check("req_ready",  64'(o_req_ready), 64'(!m_busy));
      check("alu_start",  64'(o_alu_start), 64'(m_busy && m_k == 0));
      check("alu_in",     64'(o_alu_in), 64'(e_in));
      check("alu_opcode", 64'(o_alu_opcode), 64'(m_op_reg));
      check("rsp_valid",  64'(o_rsp_valid), 64'(e_rv));
      check("rsp_err",    64'(o_rsp_err), 64'(e_rv && m_err));
      if (e_rv) check("rsp_result", 64'(o_rsp_result), 64'(m_exp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response. rdy_delay = cycles rsp_ready stays low after
  // rsp_valid; b2b keeps req_valid high throughout and after completion.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input int rdy_delay, input bit b2b,
                         output logic [31:0] res, output logic err, output int lat,
                         output logic [63:0] bytes, output int wait_acc);
    int k;
    i_req_a = a; i_req_b = b; i_req_op = op; i_req_valid = 1'b1; i_rsp_ready = 1'b0;
    wait_acc = 0;
    while (!o_req_ready && wait_acc < 100) begin tick(); wait_acc++; end
    if (wait_acc >= 100) check("accept_timeout", 64'(wait_acc), 64'd0);
    tick();
    bytes = '0;
    k = 0;
    while (!o_rsp_valid && k < 60) begin
      if (k >= 1 && k <= 8) bytes[8*(k-1) +: 8] = o_alu_in;
      i_req_valid = b2b ? 1'b1 : 1'($urandom % 2);
      i_req_a = $urandom; i_req_b = $urandom; i_req_op = 2'($urandom % 2);
      tick();
      k++;
    end
    if (k >= 60) check("rsp_valid_timeout", 64'(k), 64'd0);
    lat = k;
    res = o_rsp_result;
    err = o_rsp_err;
    i_req_valid = 1'b1;
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      check("bp_result_stable", 64'(o_rsp_result), 64'(res));
      check("bp_rsp_valid", 64'(o_rsp_valid), 64'd1);
      check("bp_req_ready", 64'(o_req_ready), 64'd0);
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    i_req_valid = b2b;
    check("req_ready_after_hs", 64'(o_req_ready), 64'd1);
    $display("txn a=%08h b=%08h op=%0d dly=%0d tmo=%0b -> result=%08h err=%0b lat=%0d",
             a, b, op, alu_dly, alu_tie0, res, err, lat);
  endtask

  initial begin
    logic [31:0] res;
    logic        err;
    int          lat, wacc;
    logic [63:0] bytes;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          rdly;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Add 1.0 + 2.0, nominal ALU.
    alu_dly = 2; alu_tie0 = 1'b0;
    run_txn(32'h3F800000, 32'h40000000, OP_ADD, 0, 1'b0, res, err, lat, bytes, wacc);
    check("add_bytes",  bytes, 64'h40000000_3F800000);
    check("add_result", 64'(res), 64'h40400000);
    check("add_err",    64'(err), 64'd0);
    check("add_latency", 64'(lat), 64'd15);

    // Subtract 3.0 - 1.0.
    run_txn(32'h40400000, 32'h3F800000, OP_SUB, 0, 1'b0, res, err, lat, bytes, wacc);
    check("sub_result", 64'(res), 64'h40000000);
    check("sub_opcode", 64'(o_alu_opcode), 64'd1);
    check("sub_latency", 64'(lat), 64'd15);

    // Backpressure for 5 cycles with req_valid asserted meanwhile.
    run_txn(32'h40000000, 32'h40000000, OP_ADD, 5, 1'b0, res, err, lat, bytes, wacc);
    check("bp_result", 64'(res), 64'h40800000);

    // ALU never responds: watchdog error, then a normal request.
    alu_tie0 = 1'b1;
    run_txn(32'h3F800000, 32'h40000000, OP_ADD, 1, 1'b0, res, err, lat, bytes, wacc);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_result", 64'(res), 64'd0);
    check("tmo_latency", 64'(lat), 64'(9 + TMO));
    alu_tie0 = 1'b0;
    run_txn(32'h3F800000, 32'h40000000, OP_ADD, 0, 1'b0, res, err, lat, bytes, wacc);
    check("post_tmo_result", 64'(res), 64'h40400000);
    check("post_tmo_err", 64'(err), 64'd0);

    // ALU answers on the last permitted wait cycle.
    alu_dly = 7;
    run_txn(32'h40400000, 32'h3F800000, OP_ADD, 0, 1'b0, res, err, lat, bytes, wacc);
    check("late_done_err", 64'(err), 64'd0);
    check("late_done_result", 64'(res), 64'h40800000);
    check("late_done_latency", 64'(lat), 64'd20);
    alu_dly = 2;

    // Reset in the middle of SEND (C4).
    i_req_a = 32'h40A00000; i_req_b = 32'h3F800000; i_req_op = OP_SUB; i_req_valid = 1'b1;
    wacc = 0;
    while (!o_req_ready && wacc < 100) begin tick(); wacc++; end
    tick();
    i_req_valid = 1'b0;
    repeat (4) tick();
    check("c4_alu_in", 64'(o_alu_in), 64'h40);
    rst_n = 1'b0;
    #1;
    check("midrst_alu_start", 64'(o_alu_start), 64'd0);
    check("midrst_alu_in",    64'(o_alu_in), 64'd0);
    check("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(o_req_ready), 64'd1);
    check("midrst_opcode",    64'(o_alu_opcode), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_txn(32'h3F800000, 32'h3F800000, OP_ADD, 0, 1'b0, res, err, lat, bytes, wacc);
    check("fresh_result", 64'(res), 64'h40000000);
    check("fresh_latency", 64'(lat), 64'd15);

    // Back-to-back with req_valid held high.
    run_txn(32'h3F800000, 32'h40000000, OP_ADD, 0, 1'b1, res, err, lat, bytes, wacc);
    check("b2b1_result", 64'(res), 64'h40400000);
    run_txn(32'h40400000, 32'h3F800000, OP_SUB, 0, 1'b0, res, err, lat, bytes, wacc);
    check("b2b2_wait", 64'(wacc), 64'd0);
    check("b2b2_result", 64'(res), 64'h40000000);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      ra = rand_fp(); rb = rand_fp(); rop = 2'($urandom % 2);
      rdly = $urandom_range(1, 7);
      alu_dly  = rdly;
      alu_tie0 = ($urandom % 8 == 0);
      run_txn(ra, rb, rop, $urandom_range(0, 3), 1'($urandom % 2), res, err, lat, bytes, wacc);
      check("rnd_result", 64'(res), alu_tie0 ? 64'd0 : 64'(fp_calc(ra, rb, rop)));
      check("rnd_err", 64'(err), 64'(alu_tie0));
      check("rnd_latency", 64'(lat), alu_tie0 ? 64'(9 + TMO) : 64'(13 + rdly));
      i_req_valid = 1'b0;
      alu_tie0 = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
